multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Next-generation control unit for the LittleChip RV32I core.
- Replaces the purely combinational opcode decoder with a multicycle FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Drives the datapath with req/ready handshakes to instruction and data memory and a bounded wait timeout.
- Adds a retired-instruction counter and a sticky trap on illegal opcodes.

Parameters:
- MEM_WAIT_MAX, 16: maximum wait cycles per memory handshake before a timeout trap; must be ≥1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction bits [6:0] from the IR
- branch_taken  in  1  branch comparator result, valid in EXEC
- stall  in  1  global hold
- imem_req  out  1  fetch request
- imem_ready  in  1  fetch complete
- dmem_req  out  1  data request
- dmem_we  out  1  data request is a store
- dmem_ready  in  1  data complete
- ir_write  out  1  latch the IR
- pc_write  out  1  update the PC
- pc_src  out  2  PC source: 00 pc+4, 01 branch target, 10 ALU result
- reg_write  out  1  register-file write enable
- mem_to_reg  out  2  writeback source: 00 ALU, 01 memory, 10 pc+4
- alu_src_a  out  2  ALU A select: 00 rs1, 01 zero, 10 pc
- alu_src_b  out  2  ALU B select: 00 rs2, 01 imm, 10 const 4
- alu_op  out  2  ALU op class: 00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- retire  out  1  one-cycle pulse when an instruction completes
- retire_cnt  out  CNT_W  count of retired instructions
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to FETCH.
  - retire_cnt=0, trap=0, trap_cause=00, wait counter=0.
  - All enables, requests and retire are 0; all select outputs are 00.
- All outputs are decoded from registered state plus opcode, branch_taken and the ready inputs. There is no combinational path from stall to the request outputs.
- FETCH:
  - imem_req=1 and is held until imem_ready.
  - When imem_ready=1: ir_write=1 that cycle, then go to DECODE.
- DECODE:
  - Classify opcode against the Opcode.vh constants.
  - Unknown opcode: go to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC, ALU settings by class:
  - R-type: a=00, b=00, op=10.
  - I-type: a=00, b=01, op=11.
  - LOAD and STORE: a=00, b=01, op=00.
  - LUI: a=01, b=01, op=00.
  - AUIPC: a=10, b=01, op=00.
  - JAL: a=10, b=01, op=00.
  - JALR: a=00, b=01, op=00.
  - BRANCH: a=00, b=00, op=01.
- EXEC, next action by class:
  - BRANCH: pc_write=1, pc_src = branch_taken ? 01 : 00, retire=1, then go to FETCH.
  - LOAD and STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1 is held until dmem_ready; dmem_we=1 for STORE.
  - STORE on dmem_ready: pc_write=1, pc_src=00, retire=1, then go to FETCH.
  - LOAD on dmem_ready: go to WB.
- WB:
  - reg_write=1.
  - mem_to_reg: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_write=1; pc_src is 10 for JAL/JALR, 00 otherwise.
  - retire=1, then go to FETCH.
- Latencies without waits:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH and on entry to MEM; increments each cycle that ready=0.
  - If the count reaches MEM_WAIT_MAX with ready still 0, go to TRAP with cause 10 (FETCH) or 11 (MEM). The request drops the following cycle.
  - If ready arrives in the same cycle as the limit, it wins: the handshake completes normally.
- Stall:
  - In DECODE, EXEC and WB, stall=1 holds the state and forces pc_write, reg_write and retire to 0. Select outputs keep their values.
  - In FETCH and MEM, stall is ignored: an in-flight handshake must complete, and the stall takes effect in the next state.
- retire_cnt increments on every retire pulse and wraps modulo 2^CNT_W.
- TRAP:
  - Absorbing: only rst_n leaves it.
  - trap=1 and trap_cause is held.
  - All requests, enables and retire are 0.
- Reset asserted mid-handshake drops the request asynchronously.

Decomposition:
- Shared package `ctrl_pkg`:
  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
  - Select encodings for pc_src, mem_to_reg, alu_src_a, alu_src_b and alu_op.
  - trap_cause codes.
  - Opcode constants are reused from Opcode.vh.
- One combinational sub-module `opcode_class`: maps opcode to a one-hot class vector plus an illegal flag. It is unit-tested separately.

Test Plan:
- ADDI (opcode 0010011), imem_ready asserted one cycle after req → ir_write at cycle 1; EXEC a=00, b=01, op=11; WB reg_write=1, mem_to_reg=00; retire at cycle 4; retire_cnt=1.
- LOAD (0000011), dmem_ready held low 3 cycles → dmem_req=1 and dmem_we=0 for 4 cycles; WB mem_to_reg=01; total latency 8 cycles.
- BRANCH (1100011) with branch_taken=1, then again with branch_taken=0 → EXEC pc_write=1 with pc_src=01, then pc_src=00; reg_write never 1; retire_cnt=2.
- Opcode 1111111 → DECODE to TRAP; trap=1, trap_cause=01; no further imem_req for 20 cycles; rst_n pulse returns to FETCH with retire_cnt=0.
- imem_ready held low (MEM_WAIT_MAX=16) → TRAP with cause 10 after 16 wait cycles. Same setup with ready arriving on cycle 16 → normal DECODE.
- stall=1 for 3 cycles in EXEC of JAL (1101111) → state_dbg stays 2, no pc_write; after release, WB has pc_src=10, mem_to_reg=10, reg_write=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, datapath selects,
// trap causes, opcode constants and the per-class ALU setup table.
package ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_ZERO = 2'b01;
    localparam logic [1:0] A_PC   = 2'b10;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    // RV32I base opcodes, same values as Opcode.vh
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int NUM_CLS    = 9;
    localparam int CLS_RTYPE  = 0;
    localparam int CLS_ITYPE  = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_LUI    = 4;
    localparam int CLS_AUIPC  = 5;
    localparam int CLS_JAL    = 6;
    localparam int CLS_JALR   = 7;
    localparam int CLS_BRANCH = 8;

    typedef logic [NUM_CLS-1:0] cls_vec_t;

    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] op;
    } alu_sel_t;

    // Load, store and JALR share the plain rs1+imm address add.
    function automatic alu_sel_t alu_sel_for(input cls_vec_t cls);
        alu_sel_t s;
        s = '{src_a: A_RS1, src_b: B_IMM, op: ALU_ADD};
        if (cls[CLS_RTYPE])  s = '{src_a: A_RS1,  src_b: B_RS2, op: ALU_RTYPE};
        if (cls[CLS_ITYPE])  s = '{src_a: A_RS1,  src_b: B_IMM, op: ALU_ITYPE};
        if (cls[CLS_LUI])    s = '{src_a: A_ZERO, src_b: B_IMM, op: ALU_ADD};
        if (cls[CLS_AUIPC])  s = '{src_a: A_PC,   src_b: B_IMM, op: ALU_ADD};
        if (cls[CLS_JAL])    s = '{src_a: A_PC,   src_b: B_IMM, op: ALU_ADD};
        if (cls[CLS_BRANCH]) s = '{src_a: A_RS1,  src_b: B_RS2, op: ALU_BRANCH};
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier: one-hot class vector plus illegal flag
// for anything outside the supported RV32I base opcodes.
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output cls_vec_t   class_o,
    output logic       illegal_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OPC_OP:     class_o[CLS_RTYPE]  = 1'b1;
            OPC_OP_IMM: class_o[CLS_ITYPE]  = 1'b1;
            OPC_LOAD:   class_o[CLS_LOAD]   = 1'b1;
            OPC_STORE:  class_o[CLS_STORE]  = 1'b1;
            OPC_LUI:    class_o[CLS_LUI]    = 1'b1;
            OPC_AUIPC:  class_o[CLS_AUIPC]  = 1'b1;
            OPC_JAL:    class_o[CLS_JAL]    = 1'b1;
            OPC_JALR:   class_o[CLS_JALR]   = 1'b1;
            OPC_BRANCH: class_o[CLS_BRANCH] = 1'b1;
            default:    class_o = '0;
        endcase
        illegal_o = (class_o == '0);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the LittleChip RV32I datapath, with bounded memory
// handshakes, a retired-instruction counter and a sticky trap.
//
//   state  | meaning
//   FETCH  | imem request held until ready; IR latched on ready
//   DECODE | classify opcode; illegal opcode traps
//   EXEC   | ALU setup; branches resolve and retire here
//   MEM    | dmem request held until ready; stores retire here
//   WB     | register writeback, PC update, retire
//   TRAP   | absorbing until reset; cause held
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             stall,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_dbg
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              active_q;

    cls_vec_t cls;
    logic     illegal;
    alu_sel_t alu_sel;
    logic     is_load, is_store, is_branch, is_jump;

    opcode_class u_opcode_class (
        .opcode_i  (opcode),
        .class_o   (cls),
        .illegal_o (illegal)
    );

    assign is_load   = cls[CLS_LOAD];
    assign is_store  = cls[CLS_STORE];
    assign is_branch = cls[CLS_BRANCH];
    assign is_jump   = cls[CLS_JAL] | cls[CLS_JALR];
    assign alu_sel   = alu_sel_for(cls);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        mem_to_reg = WB_ALU;
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_op     = ALU_ADD;
        retire     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // active_q keeps the request low for the first cycle after reset
                if (active_q) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (wait_q == WAIT_LIMIT) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_IMEM_TO;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end

            ST_DECODE: begin
                if (!stall) begin
                    if (illegal) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                alu_src_a = alu_sel.src_a;
                alu_src_b = alu_sel.src_b;
                alu_op    = alu_sel.op;
                if (is_branch) begin
                    pc_src = branch_taken ? PC_BRANCH : PC_PLUS4;
                    if (!stall) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                        wait_d   = '0;
                    end
                end else if (is_load || is_store) begin
                    if (!stall) begin
                        state_d = ST_MEM;
                        wait_d  = '0;
                    end
                end else if (!stall) begin
                    state_d = ST_WB;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                        wait_d   = '0;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_WB: begin
                mem_to_reg = is_load ? WB_MEM : (is_jump ? WB_PC4 : WB_ALU);
                pc_src     = is_jump ? PC_ALU : PC_PLUS4;
                if (!stall) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                    wait_d    = '0;
                end
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end
        endcase
    end

    assign retire_cnt_d = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            wait_q       <= '0;
            retire_cnt_q <= '0;
            cause_q      <= CAUSE_NONE;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            retire_cnt_q <= retire_cnt_d;
            cause_q      <= cause_d;
            active_q     <= 1'b1;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes a per-instruction expectation
// built from latency/selection rules, the monitor pops it on each retire or trap.
module tb_multicycle_ctrl;

    localparam int MAXW = 16;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic          branch_taken = 1'b0;
    logic          stall = 1'b0;
    logic          imem_req, imem_ready = 1'b0;
    logic          dmem_req, dmem_we, dmem_ready = 1'b0;
    logic          ir_write, pc_write, reg_write, retire, trap;
    logic [1:0]    pc_src, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap_cause;
    logic [CW-1:0] retire_cnt;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .stall(stall), .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
        .retire_cnt(retire_cnt), .trap(trap), .trap_cause(trap_cause),
        .state_dbg(state_dbg)
    );

    typedef struct {
        bit is_trap;
        int cause;
        int lat;
        int ir_at;
        int a, b, op;
        int rw, m2r, pcs;
        int dreq, dwe;
        int exec_cyc;
        int cnt_before;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endfunction

    // class code: 0 R,1 I,2 LOAD,3 STORE,4 LUI,5 AUIPC,6 JAL,7 JALR,8 BRANCH,-1 illegal
    function automatic int classify(input logic [6:0] o);
        case (o)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b0110111: return 4;
            7'b0010111: return 5;
            7'b1101111: return 6;
            7'b1100111: return 7;
            7'b1100011: return 8;
            default:    return -1;
        endcase
    endfunction

    function automatic exp_t model(input logic [6:0] o, input bit taken,
                                   input int fw, input int mw, input int se, input int sw);
        exp_t e;
        int   c;
        bit   ldst, wbc;
        c = classify(o);
        e.is_trap = 0; e.cause = 0; e.lat = 0; e.ir_at = fw;
        e.a = 0; e.b = 0; e.op = 0; e.rw = 0; e.m2r = 0; e.pcs = 0;
        e.dreq = 0; e.dwe = 0; e.exec_cyc = 1 + se; e.cnt_before = model_cnt;
        case (c)
            0: begin e.a = 0; e.b = 0; e.op = 2; end
            1: begin e.a = 0; e.b = 1; e.op = 3; end
            4: begin e.a = 1; e.b = 1; e.op = 0; end
            5, 6: begin e.a = 2; e.b = 1; e.op = 0; end
            8: begin e.a = 0; e.b = 0; e.op = 1; end
            default: begin e.a = 0; e.b = 1; e.op = 0; end
        endcase
        ldst = (c == 2 || c == 3);
        wbc  = (c >= 0 && c != 3 && c != 8);
        if (fw > MAXW) begin
            e.is_trap = 1; e.cause = 2; e.lat = MAXW + 1;
        end else if (c < 0) begin
            e.is_trap = 1; e.cause = 1; e.lat = fw + 2;
        end else if (ldst && mw > MAXW) begin
            e.is_trap = 1; e.cause = 3; e.lat = fw + 3 + se + MAXW + 1;
            e.dreq = MAXW + 1;
        end else begin
            e.lat  = (fw + 1) + 1 + (1 + se) + (ldst ? mw + 1 : 0) + (wbc ? 1 + sw : 0);
            e.rw   = wbc ? 1 : 0;
            e.m2r  = (c == 2) ? 1 : ((c == 6 || c == 7) ? 2 : 0);
            e.pcs  = (c == 8) ? (taken ? 1 : 0) : ((c == 6 || c == 7) ? 2 : 0);
            e.dreq = ldst ? mw + 1 : 0;
            e.dwe  = (c == 3) ? mw + 1 : 0;
            model_cnt = (model_cnt + 1) % (1 << CW);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_retire_cnt", retire_cnt, 0);
        chk("rst_trap", {trap, trap_cause}, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_reqs", {imem_req, dmem_req, dmem_we}, 0);
        chk("rst_enables", {ir_write, pc_write, reg_write, retire}, 0);
        chk("rst_selects", {pc_src, mem_to_reg, alu_src_a, alu_src_b, alu_op}, 0);
        model_cnt = 0;
        exp_q.delete();
        imem_ready = 1'b0; dmem_ready = 1'b0; stall = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic trap_tail();
        repeat (20) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            stall      = 1'($urandom_range(0, 1));
            step();
        end
        imem_ready = 1'b0; dmem_ready = 1'b0; stall = 1'b0;
        chk("trap_event_seen", exp_q.size(), 0);
        do_reset();
    endtask

    task automatic wait_fetch(output bit ok);
        int g = 0;
        while (!imem_req && g < 4) begin
            step();
            g++;
        end
        ok = imem_req;
        if (!ok) begin
            chk("fetch_start", imem_req, 1);
            do_reset();
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input bit taken, input int fw,
                             input int mw, input int se, input int sw);
        exp_t e;
        bit   ok;
        int   c, nf, nm;
        c = classify(o);
        opcode = o;
        branch_taken = taken;
        wait_fetch(ok);
        if (!ok) return;
        e = model(o, taken, fw, mw, se, sw);
        exp_q.push_back(e);
        nf = (fw > MAXW) ? MAXW + 1 : fw + 1;
        for (int i = 0; i < nf; i++) begin
            imem_ready = (i == fw);
            stall = 1'($urandom_range(0, 1));
            step();
        end
        imem_ready = 1'b0;
        if (e.is_trap && e.cause == 2) begin trap_tail(); return; end
        stall = 1'b0;
        step();
        if (c < 0) begin trap_tail(); return; end
        repeat (se) begin stall = 1'b1; step(); end
        stall = 1'b0;
        step();
        if (c == 2 || c == 3) begin
            nm = (mw > MAXW) ? MAXW + 1 : mw + 1;
            for (int i = 0; i < nm; i++) begin
                dmem_ready = (i == mw);
                stall = 1'($urandom_range(0, 1));
                step();
            end
            dmem_ready = 1'b0;
            stall = 1'b0;
            if (e.is_trap) begin trap_tail(); return; end
        end
        if (c >= 0 && c != 3 && c != 8) begin
            repeat (sw) begin stall = 1'b1; step(); end
            stall = 1'b0;
            step();
        end
        if (exp_q.size() != 0) begin
            chk("retire_seen", exp_q.size(), 0);
            do_reset();
        end
    endtask

    // Monitor: per-instruction tallies, popped against the scoreboard on retire/trap.
    bit in_instr = 0, in_trap = 0, alu_chg = 0;
    int cyc, ir_cnt, ir_at, pcw_cnt, rw_cnt, dreq, dwe, ex_cyc, t_cause;
    int cap_a, cap_b, cap_op, cap_m2r, cap_pcs;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_instr = 0;
                in_trap  = 0;
            end else if (in_trap) begin
                chk("trap_no_req", {imem_req, dmem_req}, 0);
                chk("trap_no_enable", {retire, pc_write, reg_write, ir_write}, 0);
                chk("trap_flag", trap, 1);
                chk("trap_cause_held", trap_cause, t_cause);
            end else begin
                if (!in_instr && imem_req) begin
                    in_instr = 1; cyc = 0; ir_cnt = 0; ir_at = -1; pcw_cnt = 0;
                    rw_cnt = 0; dreq = 0; dwe = 0; ex_cyc = 0; alu_chg = 0;
                    cap_a = -1; cap_b = -1; cap_op = -1; cap_m2r = -1; cap_pcs = -1;
                end
                if (in_instr) begin
                    if (ir_write) begin ir_cnt++; ir_at = cyc; end
                    if (pc_write) begin pcw_cnt++; cap_pcs = pc_src; end
                    if (reg_write) begin rw_cnt++; cap_m2r = mem_to_reg; end
                    if (dmem_req) dreq++;
                    if (dmem_we) dwe++;
                    if (state_dbg == 3'd2) begin
                        if (ex_cyc == 0) begin
                            cap_a = alu_src_a; cap_b = alu_src_b; cap_op = alu_op;
                        end else if (cap_a != alu_src_a || cap_b != alu_src_b || cap_op != alu_op) begin
                            alu_chg = 1;
                        end
                        ex_cyc++;
                    end
                    if (trap || retire) begin
                        if (exp_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_event: actual trap=%0b retire=%0b required none", trap, retire);
                        end else begin
                            e = exp_q.pop_front();
                            chk("event_is_trap", trap, e.is_trap);
                            if (trap) begin
                                chk("trap_latency", cyc, e.lat);
                                chk("trap_cause", trap_cause, e.cause);
                                chk("trap_state", state_dbg, 5);
                                chk("trap_dmem_req_cycles", dreq, e.dreq);
                                t_cause = e.cause;
                                in_trap = 1;
                            end else begin
                                chk("latency", cyc + 1, e.lat);
                                chk("ir_write_cycle", ir_at, e.ir_at);
                                chk("ir_write_count", ir_cnt, 1);
                                chk("alu_src_a", cap_a, e.a);
                                chk("alu_src_b", cap_b, e.b);
                                chk("alu_op", cap_op, e.op);
                                chk("alu_stable", alu_chg, 0);
                                chk("exec_cycles", ex_cyc, e.exec_cyc);
                                chk("pc_write_count", pcw_cnt, 1);
                                chk("pc_src", cap_pcs, e.pcs);
                                chk("reg_write_count", rw_cnt, e.rw);
                                if (e.rw == 1) chk("mem_to_reg", cap_m2r, e.m2r);
                                chk("dmem_req_cycles", dreq, e.dreq);
                                chk("dmem_we_cycles", dwe, e.dwe);
                                chk("retire_cnt", retire_cnt, e.cnt_before);
                            end
                        end
                        in_instr = 0;
                    end else begin
                        cyc++;
                    end
                end
            end
        end
    end

    localparam logic [6:0] LEGAL [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                         7'b1100011};

    task automatic random_legal(input bit allow_traps);
        int k, fw, mw;
        logic [6:0] o;
        k  = $urandom_range(0, 99);
        o  = LEGAL[$urandom_range(0, 8)];
        fw = ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3);
        mw = ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3);
        if (allow_traps && k < 5) begin
            do o = 7'($urandom_range(0, 127)); while (classify(o) >= 0);
        end else if (allow_traps && k < 8) begin
            fw = MAXW + 1;
        end else if (allow_traps && k < 11) begin
            o  = ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'b0100011;
            mw = MAXW + 1;
        end
        run_instr(o, 1'($urandom_range(0, 1)), fw, mw, $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit ok;
        step();
        chk("rst_retire_cnt0", retire_cnt, 0);
        chk("rst_state0", state_dbg, 0);
        chk("rst_reqs0", {imem_req, dmem_req, ir_write, retire, trap}, 0);
        step();
        rst_n = 1'b1;

        run_instr(7'b0010011, 0, 1, 0, 0, 0);   // ADDI, ready one cycle late
        run_instr(7'b0000011, 0, 0, 3, 0, 0);   // LOAD, 3 dmem waits
        run_instr(7'b1100011, 1, 0, 0, 0, 0);   // BRANCH taken
        run_instr(7'b1100011, 0, 0, 0, 0, 0);   // BRANCH not taken
        run_instr(7'b1101111, 0, 0, 0, 3, 0);   // JAL, stalled in EXEC
        run_instr(7'b1100111, 0, 2, 0, 1, 2);   // JALR, stalled in WB
        run_instr(7'b0100011, 0, 0, 0, 0, 0);   // STORE
        run_instr(7'b0110111, 0, 0, 0, 0, 0);   // LUI
        run_instr(7'b0010111, 0, 0, 0, 0, 0);   // AUIPC
        run_instr(7'b0110011, 0, 0, 0, 0, 0);   // R-type
        run_instr(7'b0010011, 0, MAXW, 0, 0, 0);   // imem ready exactly at the limit
        run_instr(7'b0100011, 0, 0, MAXW, 0, 0);   // dmem ready exactly at the limit
        run_instr(7'b1111111, 0, 0, 0, 0, 0);      // illegal opcode
        run_instr(7'b0010011, 0, MAXW + 1, 0, 0, 0); // imem timeout
        run_instr(7'b0000011, 0, 1, MAXW + 1, 1, 0); // dmem timeout

        // reset in the middle of a fetch handshake
        wait_fetch(ok);
        if (ok) begin
            #2 rst_n = 1'b0;
            #1 chk("async_req_drop", imem_req, 0);
            model_cnt = 0;
            step();
            step();
            rst_n = 1'b1;
        end

        repeat (20) random_legal(0);   // enough retires to wrap the 4-bit counter
        repeat (60) random_legal(1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
